captura_operandos: RTL and testbench

- Upstream operand-entry stage for the 4-bit subtractor (`resta`) on the FPGA board.
- Operator sets the switches and presses one push-button twice: first press latches A, second press latches B.
- The block then holds A/B stable and asserts `valido` so the subtractor output S is meaningful; a third press restarts entry.
- The raw button is asynchronous and bouncy, so the block includes synchronisation, debounce and edge detection.

---
 rtl/captura_pkg.sv | 13 +
 rtl/antirrebote.sv | 72 +++++++
 rtl/captura_operandos.sv | 91 +++++++++
 tb/tb_captura_operandos.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/captura_pkg.sv
// Shared types and defaults for the operand-entry stage that feeds the 4-bit subtractor.
package captura_pkg;

   typedef enum logic [1:0] {
      ESPERA_A = 2'd0,
      ESPERA_B = 2'd1,
      LISTO    = 2'd2
   } estado_t;

   localparam int ANCHO_DEF      = 4;
   localparam int DEB_CICLOS_DEF = 500000;

endpackage

// File: rtl/antirrebote.sv
// Push-button conditioning: two-flop synchroniser, optional debounce (macro CAPTURA_DEBOUNCE_EN)
// and a registered one-cycle strobe on the debounced rising edge.
module antirrebote #(
   parameter int DEB_CICLOS = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic entrada,
   output logic pulso
);

   if (DEB_CICLOS < 1) begin : g_chk
      $error("antirrebote: DEB_CICLOS must be at least 1");
   end

   logic sync1_q;
   logic sync2_q;
   logic nivel;
   logic ant_q;
   logic pulso_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= entrada;
         sync2_q <= sync1_q;
      end
   end

`ifdef CAPTURA_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CICLOS + 1);

   logic             nivel_q;
   logic [CNT_W-1:0] cnt_q;

   // The level only flips after DEB_CICLOS consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nivel_q <= 1'b0;
         cnt_q   <= '0;
      end else if (sync2_q != nivel_q) begin
         if (cnt_q == CNT_W'(DEB_CICLOS - 1)) begin
            nivel_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign nivel = nivel_q;
`else
   assign nivel = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ant_q   <= 1'b0;
         pulso_q <= 1'b0;
      end else begin
         ant_q   <= nivel;
         pulso_q <= nivel & ~ant_q;
      end
   end

   assign pulso = pulso_q;

endmodule

// File: rtl/captura_operandos.sv
// Two-press operand capture for the subtractor: first press latches A, second latches B and
// raises valido, third press clears. Debounce is enabled by defining CAPTURA_DEBOUNCE_EN.
module captura_operandos
   import captura_pkg::*;
#(
   parameter int ANCHO      = ANCHO_DEF,
   parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ANCHO-1:0] sw,
   input  logic             btn,
   output logic [ANCHO-1:0] A,
   output logic [ANCHO-1:0] B,
   output logic             valido,
   output logic [1:0]       fase
);

   logic             pulso;
   estado_t          estado_q, estado_d;
   logic [ANCHO-1:0] a_q, a_d;
   logic [ANCHO-1:0] b_q, b_d;
   logic             valido_q, valido_d;

   antirrebote #(
      .DEB_CICLOS (DEB_CICLOS)
   ) u_antirrebote (
      .clk     (clk),
      .rst_n   (rst_n),
      .entrada (btn),
      .pulso   (pulso)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q <= ESPERA_A;
         a_q      <= '0;
         b_q      <= '0;
         valido_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         b_q      <= b_d;
         valido_q <= valido_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         ESPERA_A: if (pulso) estado_d = ESPERA_B;
         ESPERA_B: if (pulso) estado_d = LISTO;
         LISTO:    if (pulso) estado_d = ESPERA_A;
         default:  estado_d = ESPERA_A;
      endcase
   end

   // The illegal encoding also clears the operands so recovery lands in a clean ESPERA_A.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      valido_d = valido_q;
      case (estado_q)
         ESPERA_A: if (pulso) a_d = sw;
         ESPERA_B: begin
            if (pulso) begin
               b_d      = sw;
               valido_d = 1'b1;
            end
         end
         LISTO: begin
            if (pulso) begin
               a_d      = '0;
               b_d      = '0;
               valido_d = 1'b0;
            end
         end
         default: begin
            a_d      = '0;
            b_d      = '0;
            valido_d = 1'b0;
         end
      endcase
   end

   assign A      = a_q;
   assign B      = b_q;
   assign valido = valido_q;
   assign fase   = estado_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos with DEB_CICLOS=4; expected latency follows CAPTURA_DEBOUNCE_EN.
module tb_captura_operandos;

   localparam int DEB = 4;
`ifdef CAPTURA_DEBOUNCE_EN
   localparam int LAT = DEB;
`else
   localparam int LAT = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic       btn;
   logic [3:0] A;
   logic [3:0] B;
   logic       valido;
   logic [1:0] fase;

   int total;
   int bad;
   int edges;

   captura_operandos #(
      .ANCHO      (4),
      .DEB_CICLOS (DEB)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw     (sw),
      .btn    (btn),
      .A      (A),
      .B      (B),
      .valido (valido),
      .fase   (fase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // Counts edges from the first posedge after the call until fase moves; -1 if it never does.
   task automatic waitFaseChange(output int n);
      logic [1:0] f0;
      f0 = fase;
      n  = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (fase !== f0) begin
            n = i - 1;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input logic [3:0] swVal, input int holdCycles);
      sw  = swVal;
      btn = 1'b1;
      repeat (holdCycles) @(negedge clk);
      btn = 1'b0;
      repeat (LAT + 8) @(negedge clk);
   endtask

   task automatic resetDut(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      btn   = 1'b1;
      sw    = 4'b1001;

      // Reset with the button already held
      repeat (3) @(negedge clk);
      checkOutput("rst_A", {4'b0, A}, 8'h00);
      checkOutput("rst_B", {4'b0, B}, 8'h00);
      checkOutput("rst_valido", {7'b0, valido}, 8'h00);
      checkOutput("rst_fase", {6'b0, fase}, 8'h00);
      rst_n = 1'b1;
      waitFaseChange(edges);
      checkOutput("rst_held_latency", 8'(edges), 8'(3 + LAT));
      checkOutput("rst_held_A", {4'b0, A}, 8'h09);
      btn = 1'b0;
      repeat (LAT + 8) @(negedge clk);
      checkOutput("rst_held_single", {6'b0, fase}, 8'h01);

      resetDut(2);
      repeat (2) @(negedge clk);

      // Normal entry 0101 - 0011
      applyStimulus(4'b0101, LAT + 10);
      checkOutput("n1_A", {4'b0, A}, 8'h05);
      checkOutput("n1_fase", {6'b0, fase}, 8'h01);
      checkOutput("n1_valido", {7'b0, valido}, 8'h00);
      applyStimulus(4'b0011, LAT + 10);
      checkOutput("n1_B", {4'b0, B}, 8'h03);
      checkOutput("n1_valido2", {7'b0, valido}, 8'h01);
      checkOutput("n1_fase2", {6'b0, fase}, 8'h02);
      checkOutput("n1_S", {4'b0, 4'(A - B)}, 8'h02);

      // Restart clears everything on the same edge
      sw  = 4'b1111;
      btn = 1'b1;
      waitFaseChange(edges);
      checkOutput("rs1_fase", {6'b0, fase}, 8'h00);
      checkOutput("rs1_A", {4'b0, A}, 8'h00);
      checkOutput("rs1_B", {4'b0, B}, 8'h00);
      checkOutput("rs1_valido", {7'b0, valido}, 8'h00);
      btn = 1'b0;
      repeat (LAT + 8) @(negedge clk);

      // Second pair 0010 - 0100 gives S=1110
      applyStimulus(4'b0010, LAT + 10);
      applyStimulus(4'b0100, LAT + 10);
      checkOutput("n2_A", {4'b0, A}, 8'h02);
      checkOutput("n2_B", {4'b0, B}, 8'h04);
      checkOutput("n2_S", {4'b0, 4'(A - B)}, 8'h0E);
      applyStimulus(4'b0110, LAT + 10);
      checkOutput("n2_restart", {6'b0, fase}, 8'h00);

`ifdef CAPTURA_DEBOUNCE_EN
      // Bounce shorter than the debounce window
      sw = 4'b1010;
      for (int i = 0; i < 8; i++) begin
         btn = ~i[0];
         @(negedge clk);
      end
      btn = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("bounce_fase", {6'b0, fase}, 8'h00);
      checkOutput("bounce_A", {4'b0, A}, 8'h00);
      checkOutput("bounce_B", {4'b0, B}, 8'h00);
`endif

      // Long hold: one capture, nothing on release, later sw changes ignored
      sw  = 4'b1000;
      btn = 1'b1;
      waitFaseChange(edges);
      checkOutput("hold_latency", 8'(edges), 8'(3 + LAT));
      repeat (50 - edges) @(negedge clk);
      btn = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      checkOutput("hold_fase", {6'b0, fase}, 8'h01);
      checkOutput("hold_A", {4'b0, A}, 8'h08);
      sw = 4'b1111;
      repeat (10) @(negedge clk);
      checkOutput("hold_sw_ignored", {4'b0, A}, 8'h08);
      applyStimulus(4'b0010, LAT + 10);
      checkOutput("hold_B", {4'b0, B}, 8'h02);
      checkOutput("hold_valido", {7'b0, valido}, 8'h01);

      btn = 1'b1;
      waitFaseChange(edges);
      checkOutput("rs2_fase", {6'b0, fase}, 8'h00);
      checkOutput("rs2_A", {4'b0, A}, 8'h00);
      checkOutput("rs2_B", {4'b0, B}, 8'h00);
      checkOutput("rs2_valido", {7'b0, valido}, 8'h00);
      btn = 1'b0;
      repeat (LAT + 8) @(negedge clk);

      // Reset while waiting for B
      applyStimulus(4'b0111, LAT + 10);
      checkOutput("mid_fase_pre", {6'b0, fase}, 8'h01);
      sw  = 4'b0001;
      btn = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      btn   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("mid_rst_fase", {6'b0, fase}, 8'h00);
      checkOutput("mid_rst_A", {4'b0, A}, 8'h00);
      checkOutput("mid_rst_B", {4'b0, B}, 8'h00);
      checkOutput("mid_rst_valido", {7'b0, valido}, 8'h00);
      rst_n = 1'b1;
      repeat (LAT + 10) @(negedge clk);
      checkOutput("mid_rst_quiet", {6'b0, fase}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
